// File: rtl/shift_accum_pipe_pkg.sv
// Shared constants and modular arithmetic for the rotor-shift accumulator.
package shift_pkg;

  localparam int SHIFT_W_DEF   = 6;
  localparam int ROTOR_W_DEF   = 2;
  localparam int ALPHA_MOD_DEF = 64;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_BWD = 1'b1;

  // Both operands are below the modulus, so a single conditional subtract suffices.
  function automatic logic [31:0] mod_add(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [31:0] modulus
  );
    logic [31:0] sum;
    sum = a + d;
    if (sum >= modulus) begin
      sum = sum - modulus;
    end
    return sum;
  endfunction

endpackage

// File: rtl/shift_accum_pipe_delay_line.sv
// History shift register of past shift values with a saturating fill count.
module shift_delay_line #(
  parameter int SW    = 6,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  input  logic [SW-1:0] din,
  output logic [SW-1:0] dout,
  output logic          full
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [SW-1:0] stage [DEPTH];
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
      count <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
      count <= '0;
    end else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
      if (count != CW'(DEPTH)) begin
        count <= count + 1'b1;
      end
    end
  end

  assign dout = stage[DEPTH-1];
  assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/shift_accum_pipe.sv
// Rotor-shift accumulator: modular running shift, one-entry valid/ready result
// register and a history line feeding later pipeline stages.
module shift_accum_pipe
  import shift_pkg::*;
#(
  parameter int SW         = SHIFT_W_DEF,
  parameter int RW         = ROTOR_W_DEF,
  parameter int MOD        = ALPHA_MOD_DEF,
  parameter int PIPE_DEPTH = 2,
  parameter int AUTO_CLEAR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [RW-1:0] in_delta_fwd,
  input  logic [RW-1:0] in_delta_bwd,
  output logic [SW-1:0] shift_backward,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] shift_accu,
  output logic [SW-1:0] shift_accu_pipe,
  output logic          hist_full
);

  generate
    if (MOD < (1 << RW) || MOD > (1 << SW) || PIPE_DEPTH < 1) begin : g_bad_param
      $error("shift_accum_pipe: illegal MOD/RW/SW/PIPE_DEPTH combination");
    end
  endgenerate

  logic [SW-1:0] acc;
  logic [SW-1:0] result;
  logic          result_valid;
  logic          accept;
  logic          transfer;
  logic [RW-1:0] delta;
  logic [SW-1:0] nxt;

  // A clear cycle refuses input so the cleared accumulator is not overwritten.
  assign in_ready = !clear && (!result_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign transfer = result_valid && out_ready;

  assign delta = (in_mode == MODE_BWD) ? in_delta_bwd : in_delta_fwd;
  assign nxt   = SW'(mod_add(32'(acc), 32'(delta), 32'(MOD)));

  assign shift_backward = SW'(mod_add(32'(acc), 32'(in_delta_bwd), 32'(MOD)));

  // Legacy mode drops the running shift on every edge without an accepted step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (accept) begin
      acc <= nxt;
    end else if (AUTO_CLEAR != 0) begin
      acc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else if (accept) begin
      result       <= nxt;
      result_valid <= 1'b1;
    end else if (transfer) begin
      result_valid <= 1'b0;
    end
  end

  shift_delay_line #(
    .SW    (SW),
    .DEPTH (PIPE_DEPTH)
  ) u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .en    (accept),
    .din   (nxt),
    .dout  (shift_accu_pipe),
    .full  (hist_full)
  );

  assign out_valid  = result_valid;
  assign shift_accu = result;

endmodule

// File: tb/tb_shift_accum_pipe.sv
// Directed checks of shift_accum_pipe: default, MOD=26 and AUTO_CLEAR=1 builds
// share one stimulus stream; each scenario checks the relevant instance.
module tb_shift_accum_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_mode = 1'b0;
  logic [1:0] fwd = 2'd0;
  logic [1:0] bwd = 2'd0;
  logic       out_ready = 1'b1;

  logic       a_in_ready, a_out_valid, a_hist_full;
  logic [5:0] a_shift_backward, a_shift_accu, a_shift_accu_pipe;
  logic       m_in_ready, m_out_valid, m_hist_full;
  logic [4:0] m_shift_backward, m_shift_accu, m_shift_accu_pipe;
  logic       c_in_ready, c_out_valid, c_hist_full;
  logic [5:0] c_shift_backward, c_shift_accu, c_shift_accu_pipe;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_accum_pipe dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_mode(in_mode), .in_delta_fwd(fwd), .in_delta_bwd(bwd),
    .shift_backward(a_shift_backward), .out_valid(a_out_valid), .out_ready(out_ready),
    .shift_accu(a_shift_accu), .shift_accu_pipe(a_shift_accu_pipe), .hist_full(a_hist_full)
  );

  shift_accum_pipe #(.SW(5), .RW(2), .MOD(26)) dut_m (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_mode(in_mode), .in_delta_fwd(fwd), .in_delta_bwd(bwd),
    .shift_backward(m_shift_backward), .out_valid(m_out_valid), .out_ready(out_ready),
    .shift_accu(m_shift_accu), .shift_accu_pipe(m_shift_accu_pipe), .hist_full(m_hist_full)
  );

  shift_accum_pipe #(.AUTO_CLEAR(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_mode(in_mode), .in_delta_fwd(fwd), .in_delta_bwd(bwd),
    .shift_backward(c_shift_backward), .out_valid(c_out_valid), .out_ready(out_ready),
    .shift_accu(c_shift_accu), .shift_accu_pipe(c_shift_accu_pipe), .hist_full(c_hist_full)
  );

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #2;
    rst_n     = 1'b1;
  endtask

  task automatic step(input logic m, input logic [1:0] f, input logic [1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = m;
    fwd      = f;
    bwd      = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (a_shift_accu !== 6'd0) begin errors++; $display("FAIL reset_shift_accu: got %0d expected 0", a_shift_accu); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", a_out_valid); end
    checks++; if (a_hist_full !== 1'b0) begin errors++; $display("FAIL reset_hist_full: got %0b expected 0", a_hist_full); end
    checks++; if (a_shift_accu_pipe !== 6'd0) begin errors++; $display("FAIL reset_pipe: got %0d expected 0", a_shift_accu_pipe); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", a_in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_forward();
    logic [5:0] exp_acc [3];
    logic [5:0] exp_pipe [3];
    logic       exp_full [3];
    logic [1:0] deltas [3];
    deltas   = '{2'd3, 2'd2, 2'd1};
    exp_acc  = '{6'd3, 6'd5, 6'd6};
    exp_pipe = '{6'd0, 6'd3, 6'd5};
    exp_full = '{1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, deltas[i], 2'd0);
      checks++; if (a_shift_accu !== exp_acc[i]) begin errors++; $display("FAIL fwd_shift_accu[%0d]: got %0d expected %0d", i, a_shift_accu, exp_acc[i]); end
      checks++; if (a_shift_accu_pipe !== exp_pipe[i]) begin errors++; $display("FAIL fwd_pipe[%0d]: got %0d expected %0d", i, a_shift_accu_pipe, exp_pipe[i]); end
      checks++; if (a_hist_full !== exp_full[i]) begin errors++; $display("FAIL fwd_hist_full[%0d]: got %0b expected %0b", i, a_hist_full, exp_full[i]); end
      $display("fwd step %0d delta=%0d shift_accu=%0d pipe=%0d", i, deltas[i], a_shift_accu, a_shift_accu_pipe);
    end
    @(negedge clk);
    bwd = 2'd3;
    #1;
    checks++; if (a_shift_backward !== 6'd9) begin errors++; $display("FAIL fwd_shift_backward: got %0d expected 9", a_shift_backward); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 2'd3, 2'd0);
    step(1'b0, 2'd1, 2'd0);
    checks++; if (m_shift_accu !== 5'd25) begin errors++; $display("FAIL wrap_pre: got %0d expected 25", m_shift_accu); end
    @(negedge clk);
    bwd = 2'd3;
    #1;
    checks++; if (m_shift_backward !== 5'd2) begin errors++; $display("FAIL wrap_bwd_comb: got %0d expected 2", m_shift_backward); end
    step(1'b0, 2'd3, 2'd0);
    checks++; if (m_shift_accu !== 5'd2) begin errors++; $display("FAIL wrap_fwd: got %0d expected 2", m_shift_accu); end
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b1; fwd = 2'd3; bwd = 2'd0;
    #1;
    checks++; if (m_shift_backward !== 5'd2) begin errors++; $display("FAIL wrap_bwd0_comb: got %0d expected 2", m_shift_backward); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (m_shift_accu !== 5'd2) begin errors++; $display("FAIL wrap_bwd0: got %0d expected 2", m_shift_accu); end
    $display("wrap mod26 shift_accu=%0d", m_shift_accu);
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1'b0, 2'd1, 2'd0);
    checks++; if (a_shift_accu !== 6'd1) begin errors++; $display("FAIL bp_first: got %0d expected 1", a_shift_accu); end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; fwd = 2'd2; bwd = 2'd0;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %0b expected 0", a_in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (a_shift_accu !== 6'd1 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got %0d/%0b expected 1/1", i, a_shift_accu, a_out_valid); end
      checks++; if (a_shift_backward !== 6'd1 || a_hist_full !== 1'b0) begin errors++; $display("FAIL bp_acc_hold[%0d]: got %0d/%0b expected 1/0", i, a_shift_backward, a_hist_full); end
      $display("stall cycle %0d shift_accu=%0d", i, a_shift_accu);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_high: got %0b expected 1", a_in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (a_shift_accu !== 6'd3) begin errors++; $display("FAIL bp_resume: got %0d expected 3", a_shift_accu); end
    checks++; if (a_shift_accu_pipe !== 6'd1 || a_hist_full !== 1'b1) begin errors++; $display("FAIL bp_hist: got %0d/%0b expected 1/1", a_shift_accu_pipe, a_hist_full); end
  endtask

  task automatic test_auto_clear();
    do_reset();
    step(1'b0, 2'd3, 2'd0);
    checks++; if (c_shift_accu !== 6'd3) begin errors++; $display("FAIL ac_first: got %0d expected 3", c_shift_accu); end
    @(posedge clk);
    #1;
    checks++; if (c_shift_accu !== 6'd3) begin errors++; $display("FAIL ac_idle_hold: got %0d expected 3", c_shift_accu); end
    step(1'b0, 2'd1, 2'd0);
    checks++; if (c_shift_accu !== 6'd1) begin errors++; $display("FAIL ac_after_idle: got %0d expected 1", c_shift_accu); end
    checks++; if (a_shift_accu !== 6'd4) begin errors++; $display("FAIL hold_after_idle: got %0d expected 4", a_shift_accu); end
    $display("auto_clear=1 shift_accu=%0d, auto_clear=0 shift_accu=%0d", c_shift_accu, a_shift_accu);
  endtask

  task automatic test_clear();
    do_reset();
    step(1'b0, 2'd3, 2'd0);
    step(1'b0, 2'd3, 2'd0);
    checks++; if (a_shift_accu !== 6'd6 || a_hist_full !== 1'b1) begin errors++; $display("FAIL clr_pre: got %0d/%0b expected 6/1", a_shift_accu, a_hist_full); end
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_mode = 1'b0; fwd = 2'd1; bwd = 2'd0; out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin errors++; $display("FAIL clr_ready: got %0b/%0b expected 0/1", a_in_ready, a_out_valid); end
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_shift_accu !== 6'd6) begin errors++; $display("FAIL clr_transfer: got %0b/%0d expected 0/6", a_out_valid, a_shift_accu); end
    checks++; if (a_hist_full !== 1'b0 || a_shift_accu_pipe !== 6'd0 || a_shift_backward !== 6'd0) begin errors++; $display("FAIL clr_state: got %0b/%0d/%0d expected 0/0/0", a_hist_full, a_shift_accu_pipe, a_shift_backward); end
    step(1'b0, 2'd2, 2'd0);
    checks++; if (a_shift_accu !== 6'd2 || a_shift_accu_pipe !== 6'd0 || a_hist_full !== 1'b0) begin errors++; $display("FAIL clr_next: got %0d/%0d/%0b expected 2/0/0", a_shift_accu, a_shift_accu_pipe, a_hist_full); end
    $display("clear then step shift_accu=%0d", a_shift_accu);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 13; i++) step(1'b0, 2'd3, 2'd0);
    step(1'b0, 2'd1, 2'd0);
    checks++; if (a_shift_accu !== 6'd40 || a_out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre: got %0d/%0b expected 40/1", a_shift_accu, a_out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_shift_accu !== 6'd0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL ar_out: got %0d/%0b expected 0/0", a_shift_accu, a_out_valid); end
    checks++; if (a_hist_full !== 1'b0 || a_shift_accu_pipe !== 6'd0 || a_shift_backward !== 6'd0) begin errors++; $display("FAIL ar_state: got %0b/%0d/%0d expected 0/0/0", a_hist_full, a_shift_accu_pipe, a_shift_backward); end
    #1;
    rst_n = 1'b1;
    step(1'b0, 2'd1, 2'd0);
    checks++; if (a_shift_accu !== 6'd1) begin errors++; $display("FAIL ar_first_step: got %0d expected 1", a_shift_accu); end
    $display("after async reset shift_accu=%0d", a_shift_accu);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_wrap();
    test_backpressure();
    test_auto_clear();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
